bus_arbiter_mux: RTL

BUS_ARBITER_MUX -- requirements
Module: bus_arbiter_mux

---
 rtl/bus_arbiter_mux.sv | 109 ++++++++++
 1 files changed

// File: rtl/bus_arbiter_mux.sv
// ============================================================================
// Module      : bus_arbiter_mux
// Description : N-channel arbiter feeding a single registered output word.
//               Round-robin or fixed-priority arbitration, valid/ready
//               handshakes on both sides, one-word output register that can
//               drain and reload on the same edge for full throughput.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arbiter_mux #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SELW     = $clog2(CHANNELS)
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic [CHANNELS*WIDTH-1:0] In_data,
  input  logic [CHANNELS-1:0]       In_valid,
  output logic [CHANNELS-1:0]       In_ready,
  input  logic                      Mode,
  output logic [WIDTH-1:0]          Out_data,
  output logic [SELW-1:0]           Out_chan,
  output logic                      Out_valid,
  input  logic                      Out_ready
);

  localparam logic [SELW:0]   CH_EXT  = (SELW+1)'(CHANNELS);
  localparam logic [SELW-1:0] CH_LAST = SELW'(CHANNELS - 1);

  logic [SELW-1:0]  rr_ptr;
  logic             load;
  logic [SELW-1:0]  search_start;
  logic [SELW:0]    cand_sum;
  logic [SELW-1:0]  cand;
  logic             found;
  logic [SELW-1:0]  winner;
  logic [WIDTH-1:0] win_data;
  logic [SELW-1:0]  ptr_next;

  // The output register can take a new word when empty or being drained now.
  assign load = ~Out_valid | Out_ready;

  // Fixed priority is simply a round-robin search that always starts at 0.
  assign search_start = Mode ? '0 : rr_ptr;

  // Search upward from the start index with wrap-around; first request wins.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    cand_sum = '0;
    cand     = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      cand_sum = {1'b0, search_start} + (SELW+1)'(k);
      if (cand_sum >= CH_EXT) begin
        cand_sum = cand_sum - CH_EXT;
      end
      cand = cand_sum[SELW-1:0];
      if (!found && In_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Select the winning channel's data word.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (winner == SELW'(i)) begin
        win_data = In_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Explicit wrap keeps the pointer legal for non-power-of-two channel counts.
  assign ptr_next = (winner == CH_LAST) ? '0 : winner + 1'b1;

  // Grant only the winner, only when the output register can accept, and
  // never while reset is asserted.
  always_comb begin
    In_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      In_ready[i] = Reset_n & load & found & (winner == SELW'(i));
    end
  end

  // Output register and round-robin pointer; holds under backpressure.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Out_valid <= 1'b0;
      Out_data  <= '0;
      Out_chan  <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      if (found) begin
        Out_valid <= 1'b1;
        Out_data  <= win_data;
        Out_chan  <= winner;
        rr_ptr    <= ptr_next;
      end else begin
        Out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
